// File: rtl/addsub_digit_serial.sv
// Digit-serial two's-complement adder/subtractor: one DIGIT-wide adder slice is
// reused over WIDTH/DIGIT cycles, with valid/ready handshakes on both sides.
module addsub_digit_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic             cout,
  output logic             V,
  output logic             Z,
  output logic             N
);
  // state | meaning
  // IDLE  | waiting for an operand pair, in_ready high
  // RUN   | one digit per cycle, least significant digit first
  // DONE  | result and flags held until out_ready
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_check
    $error("addsub_digit_serial: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bx;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_ans;
  logic             r_cout;
  logic             r_v;
  logic             r_z;
  logic             r_n;

  logic             w_last;
  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT:0]   w_sum;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_ans_next;
  logic             w_in_ready;
  logic             w_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operands shift right so the active digit is always the low slice.
  assign w_last  = (r_cnt == LAST);
  assign w_a_dig = r_a[DIGIT-1:0];
  assign w_b_dig = r_bx[DIGIT-1:0];
  assign w_sum   = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {{DIGIT{1'b0}}, r_carry};
  // Carry into the top bit of the slice, recovered from that bit's sum.
  assign w_c_msb = w_sum[DIGIT-1] ^ w_a_dig[DIGIT-1] ^ w_b_dig[DIGIT-1];
  assign w_ans_next = (r_ans >> DIGIT) | (WIDTH'(w_sum[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_bx    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_ans   <= '0;
      r_cout  <= 1'b0;
      r_v     <= 1'b0;
      r_z     <= 1'b0;
      r_n     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= A;
            r_bx    <= B ^ {WIDTH{SUB}};
            r_carry <= SUB;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> DIGIT;
          r_bx    <= r_bx >> DIGIT;
          r_carry <= w_sum[DIGIT];
          r_ans   <= w_ans_next;
          if (w_last) begin
            r_cout <= w_sum[DIGIT];
            r_v    <= w_c_msb ^ w_sum[DIGIT];
            r_z    <= (w_ans_next == '0);
            r_n    <= w_ans_next[WIDTH-1];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign ans       = r_ans;
  assign cout      = r_cout;
  assign V         = r_v;
  assign Z         = r_z;
  assign N         = r_n;

endmodule

// File: doc/addsub_digit_serial.md
Name: addsub_digit_serial

Overview:
Parametrised, multi-cycle two's-complement adder/subtractor that processes a WIDTH-bit operand pair DIGIT bits per clock cycle. It is the next generation of the team's 32-bit ripple add/sub. It trades latency for area: one DIGIT-wide adder slice is reused across WIDTH/DIGIT cycles. It exposes valid/ready handshakes on both sides and returns the sum/difference with carry, signed-overflow, zero and negative flags. It sits in the datapath wherever a small-footprint ALU add/sub is needed.

Parameters:
WIDTH, 32, operand and result width in bits; must be a multiple of DIGIT.
DIGIT, 8, bits processed per cycle; 1 <= DIGIT <= WIDTH.
NDIG (localparam), WIDTH/DIGIT, number of digit cycles per operation.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operand pair valid.
in_ready  output  1  block can accept an operand pair.
A  input  WIDTH  first operand.
B  input  WIDTH  second operand.
SUB  input  1  0 = A+B, 1 = A-B.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
ans  output  WIDTH  result, modulo 2^WIDTH.
cout  output  1  carry out of the MSB. For subtraction, cout=1 means no borrow.
V  output  1  signed overflow = carry-into-MSB XOR carry-out-of-MSB.
Z  output  1  ans == 0.
N  output  1  ans[WIDTH-1].

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). Reset takes effect immediately regardless of clk.
- Reset state: FSM=IDLE, in_ready=1, out_valid=0, ans=0, cout=0, V=0, Z=0, N=0, digit counter=0, internal carry=0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch A, latch B XOR {WIDTH{SUB}}, set carry=SUB, clear counter, go to RUN.
  - Operand inputs are don't-care outside the accepting edge.
- RUN:
  - in_ready=0.
  - Each cycle, digit k (bits k*DIGIT+DIGIT-1 : k*DIGIT) = A_digit + Bx_digit + carry.
  - Write the digit into ans, update carry, increment counter.
  - On the digit with k = NDIG-1: capture carry-into-MSB and carry-out-of-MSB, set cout and V, compute Z and N from the completed result, go to DONE.
- Latency: out_valid rises exactly NDIG rising edges after the accepting edge (4 cycles at the defaults; 1 cycle when DIGIT=WIDTH).
- ans is not guaranteed stable while in RUN; consumers sample only when out_valid=1.
- DONE:
  - out_valid=1; ans and all flags are held stable.
  - On out_ready=1: out_valid drops at that edge and the FSM goes to IDLE.
  - Back-pressure of any length is supported; nothing changes while out_ready=0.
- No overlap: a new operation is accepted only in IDLE.
  - Minimum issue interval is NDIG+2 cycles with out_ready tied high.
  - in_valid during RUN/DONE is ignored and not queued.
- Flags are valid only together with out_valid.
  - V is independent of SUB and uses the carries of the complemented-B datapath.
  - Z and N reflect the full WIDTH-bit result.
- The counter is $clog2(NDIG) bits wide, minimum 1. It must not wrap mid-operation; the NDIG=1 case takes a single RUN cycle.
- Reset mid-operation (RUN or DONE): the operation is abandoned, all outputs return to reset values, no result is produced, and in_ready is 1 after reset release.
- Illegal parameters (WIDTH % DIGIT != 0) are flagged by an elaboration-time check.

Test Plan:
- Defaults, out_ready=1: A=0x00000021, B=0x00000022, SUB=0 -> ans=0x00000043, cout=0, V=0, Z=0, N=0. out_valid rises exactly 4 edges after acceptance and is high for 1 cycle.
- A=0x7FFFFFFF, B=0x00000001, SUB=0 -> ans=0x80000000, cout=0, V=1, N=1. Then A=0x80000000, B=0x00000001, SUB=1 -> ans=0x7FFFFFFF, cout=1, V=1, N=0.
- A=0x336FB7E5, B=0x336FB7E5, SUB=1 -> ans=0x00000000, cout=1, V=0, Z=1. Also A=0xFFFFFFFF, B=0x13B72214, SUB=1 -> ans=0xEC48DDEB, cout=1, V=0, N=1.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid -> ans/flags unchanged, in_ready=0 throughout, and an in_valid pulse during RUN is ignored. Raise out_ready -> IDLE next cycle, in_ready=1.
- Reset mid-RUN: assert rst_n=0 between clock edges in digit cycle 2 -> outputs immediately at reset values. After release, a new op 0xBBBBBBBB+0x44444444 -> ans=0xFFFFFFFF, cout=0, V=0, N=1.
- Parameter sweep: (WIDTH=16, DIGIT=4), (WIDTH=32, DIGIT=1), (WIDTH=32, DIGIT=32) with 1000 random ops each vs. a behavioural A±B model -> ans, cout, V, Z, N all match. Latency equals NDIG in each configuration.
